uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- Serializes 16-bit words from the accelerometer FIFO manager onto a UART TX line as two 8N1 bytes, high byte first.
- Pulses a one-cycle word-complete strobe after each word; that strobe is the manager's `wordComplete` input and advances its X/Y/Z/sync sequence.
- Sits between the FIFO manager's `DataOut` and the board TX pin.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud); minimum 2.
- GAP_CYCLES, 2, idle cycles after the complete strobe before the next word is sampled. Gives the manager time to advance its counter and update `DataOut`. Minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_Word  input  16  word to send; sampled only in IDLE
- i_Enable  input  1  level; while high, words are sent back-to-back
- o_Tx_Serial  output  1  UART line, idle high
- o_Busy  output  1  high from latch through end of GAP
- o_Word_Complete  output  1  one-cycle strobe after second stop bit
- o_Byte_Index  output  1  0 while high byte on line, 1 while low byte
- o_Word_Count  output  16  words completed since reset, wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0):
  - Outputs go immediately to: o_Tx_Serial=1, o_Busy=0, o_Word_Complete=0, o_Byte_Index=0, o_Word_Count=0.
  - State=IDLE; baud and bit counters cleared.
- All outputs are registered. o_Tx_Serial is never combinationally driven.
- States: IDLE, START, DATA, STOP, DONE, GAP.
- IDLE:
  - o_Tx_Serial=1, o_Busy=0.
  - If i_Enable=1 at edge T: latch i_Word into a 16-bit shift register, byte_idx=0, state goes to START, and o_Busy=1 from cycle T+1.
- START: o_Tx_Serial=0 for CLKS_PER_BIT cycles (T+1 .. T+CPB).
- DATA:
  - 8 bits of the current byte, LSB first, each held CLKS_PER_BIT cycles.
  - Bit i of the high byte occupies cycles starting at T+1+CPB*(1+i).
- STOP:
  - o_Tx_Serial=1 for CLKS_PER_BIT cycles.
  - If byte_idx=0: set byte_idx=1 and return to START for the low byte. There is no extra idle between bytes; the low-byte start bit begins at T+1+10*CPB.
  - If byte_idx=1: go to DONE.
- DONE (1 cycle, at T+1+20*CPB):
  - o_Word_Complete=1, o_Word_Count increments, o_Tx_Serial=1, o_Busy=1.
- GAP:
  - Lasts GAP_CYCLES cycles with o_Tx_Serial=1 and o_Busy=1, then IDLE.
  - Earliest next latch is at T+2+20*CPB+GAP_CYCLES.
- o_Byte_Index is 0 from T+1 through the high-byte stop bit, 1 from the low-byte start bit through GAP, and returns to 0 in IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary; its width is clog2(CLKS_PER_BIT).
- i_Word changes after the latch are ignored until the next IDLE sample.
- i_Enable deasserted mid-word: the current word completes fully, including DONE and GAP. No new word is latched while it is low.
- i_Enable held high: continuous stream. Each word takes exactly 20*CPB+2+GAP_CYCLES cycles, latch edge to latch edge.
- Reset mid-frame: the line returns high immediately, the partial byte is abandoned, and no o_Word_Complete is issued.
- o_Word_Complete never asserts for two consecutive cycles.

Test Plan:
- Single word:
  - Setup: CPB=4, GAP=2; i_Word=0xA55A; i_Enable pulsed for 1 cycle.
  - Line sampled mid-bit must read 0,1,0,1,0,0,1,0,1,1 (0xA5) then 0,0,1,0,1,1,0,1,0,1 (0x5A).
  - o_Word_Complete high exactly at latch+81; o_Word_Count=1; o_Busy low at latch+84.
- Stream X/Y/Z/sync:
  - Hold i_Enable=1.
  - Update i_Word 2 cycles after each o_Word_Complete, in order 0x0102, 0x0304, 0x0506, 0xFFFF.
  - Decoded bytes must be 01 02 03 04 05 06 FF FF.
  - Latch spacing must be exactly 84 cycles; o_Word_Count=4.
- Mid-frame word change: latch 0x1234, then drive i_Word=0xBEEF at latch+10 -> bytes 0x12, 0x34 sent unchanged.
- Enable drop:
  - Deassert i_Enable at latch+30 -> the full word still completes and o_Word_Complete fires once.
  - o_Tx_Serial then stays 1 and o_Busy stays 0 for 200 cycles.
- Reset mid-byte: assert rst_n=0 at latch+45 -> o_Tx_Serial=1 in the same cycle, no complete strobe, o_Word_Count=0. After release with i_Enable=1, a clean new frame starts.
- Count wrap: force 65536 completions (CPB=2) -> o_Word_Count returns to 0x0000.

Source files
------------

// File: rtl/uart_word_tx.sv
// Sends 16-bit words as two 8N1 UART bytes (high byte first) and strobes
// o_Word_Complete once per word so the upstream FIFO manager can advance.
`timescale 1ns/1ps
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_Word,
    input  logic        i_Enable,
    output logic        o_Tx_Serial,
    output logic        o_Busy,
    output logic        o_Word_Complete,
    output logic        o_Byte_Index,
    output logic [15:0] o_Word_Count
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [15:0]        word_q, word_d;
    logic               byte_idx_q, byte_idx_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bidx_q, bidx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               baud_end;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        baud_end   = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                if (i_Enable) begin
                    word_d     = i_Word;
                    byte_idx_d = 1'b0;
                    baud_d     = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Low byte follows the high byte's stop bit with no idle time.
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = S_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DONE: begin
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the state being entered so that the
        // registered copies line up exactly with state_q.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = word_d[{~byte_idx_d, bit_d}];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        bidx_d = (state_d != S_IDLE) && byte_idx_d;
        cnt_d  = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            gap_q      <= '0;
            byte_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bidx_q     <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bidx_q     <= bidx_d;
            if (done_d) begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign o_Tx_Serial     = tx_q;
    assign o_Busy          = busy_q;
    assign o_Word_Complete = done_q;
    assign o_Byte_Index    = bidx_q;
    assign o_Word_Count    = cnt_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx at CLKS_PER_BIT=4, GAP_CYCLES=2.
`timescale 1ns/1ps
module tb_uart_word_tx;

    localparam int CPB      = 4;
    localparam int GAP      = 2;
    localparam int WORD_CYC = 20*CPB + 2 + GAP;
    localparam int DONE_K   = 1 + 20*CPB;
    localparam int MID      = 1 + CPB/2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_Word = 16'h0000;
    logic        i_Enable = 1'b0;
    logic        o_Tx_Serial;
    logic        o_Busy;
    logic        o_Word_Complete;
    logic        o_Byte_Index;
    logic [15:0] o_Word_Count;

    int n_checks = 0;
    int n_fail   = 0;

    uart_word_tx #(
        .CLKS_PER_BIT(CPB),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_Word         (i_Word),
        .i_Enable       (i_Enable),
        .o_Tx_Serial    (o_Tx_Serial),
        .o_Busy         (o_Busy),
        .o_Word_Complete(o_Word_Complete),
        .o_Byte_Index   (o_Byte_Index),
        .o_Word_Count   (o_Word_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Call at the negedge of the cycle whose closing posedge latches the word.
    // k counts cycles after that latch edge; k=WORD_CYC is the next IDLE sample.
    task automatic track_word(input logic [15:0] exp_w, input logic [15:0] exp_cnt,
                              input int chg_k, input logic [15:0] chg_w, input int drop_k);
        logic [19:0] frame;
        frame = '0;
        for (int k = 1; k <= WORD_CYC; k++) begin
            @(negedge clk);
            if (k == chg_k)  i_Word = chg_w;
            if (k == drop_k) i_Enable = 1'b0;
            if (k >= MID && ((k - MID) % CPB) == 0 && ((k - MID) / CPB) < 20)
                frame[(k - MID) / CPB] = o_Tx_Serial;
            check("busy", 32'(o_Busy), 32'(k < WORD_CYC));
            check("word_complete", 32'(o_Word_Complete), 32'(k == DONE_K));
            check("byte_index", 32'(o_Byte_Index), 32'((k > 10*CPB) && (k < WORD_CYC)));
            if (k == DONE_K) check("word_count", 32'(o_Word_Count), 32'(exp_cnt));
        end
        check("start_hi", 32'(frame[0]), 32'd0);
        check("stop_hi",  32'(frame[9]), 32'd1);
        check("start_lo", 32'(frame[10]), 32'd0);
        check("stop_lo",  32'(frame[19]), 32'd1);
        check("byte_hi",  32'(frame[8:1]), 32'(exp_w[15:8]));
        check("byte_lo",  32'(frame[18:11]), 32'(exp_w[7:0]));
    endtask

    initial begin
        int bad;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx",    32'(o_Tx_Serial), 32'd1);
        check("rst_busy",  32'(o_Busy), 32'd0);
        check("rst_wc",    32'(o_Word_Complete), 32'd0);
        check("rst_bidx",  32'(o_Byte_Index), 32'd0);
        check("rst_count", 32'(o_Word_Count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, enable pulsed for one cycle
        i_Word = 16'hA55A;
        i_Enable = 1'b1;
        track_word(16'hA55A, 16'd1, 0, 16'h0000, 1);
        repeat (4) @(negedge clk);
        check("single_no_relatch", 32'(o_Busy), 32'd0);

        rst_n = 1'b0;
        @(negedge clk);
        check("count_cleared", 32'(o_Word_Count), 32'd0);
        rst_n = 1'b1;

        // Stream X/Y/Z/sync with enable held
        i_Word = 16'h0102;
        i_Enable = 1'b1;
        track_word(16'h0102, 16'd1, 83, 16'h0304, 0);
        track_word(16'h0304, 16'd2, 83, 16'h0506, 0);
        track_word(16'h0506, 16'd3, 83, 16'hFFFF, 0);
        track_word(16'hFFFF, 16'd4, 0, 16'h0000, 83);
        check("stream_count", 32'(o_Word_Count), 32'd4);

        // Word change after latch is ignored
        i_Word = 16'h1234;
        i_Enable = 1'b1;
        track_word(16'h1234, 16'd5, 10, 16'hBEEF, 83);

        // Enable dropped mid-word
        i_Word = 16'hC3A1;
        i_Enable = 1'b1;
        track_word(16'hC3A1, 16'd6, 0, 16'h0000, 30);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_Tx_Serial !== 1'b1 || o_Busy !== 1'b0 || o_Word_Complete !== 1'b0) bad++;
        end
        check("idle_after_drop", 32'(bad), 32'd0);
        check("count_after_drop", 32'(o_Word_Count), 32'd6);

        // Reset in the middle of the low byte's first data bit
        i_Word = 16'h1234;
        i_Enable = 1'b1;
        repeat (45) @(negedge clk);
        check("tx_before_rst", 32'(o_Tx_Serial), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_tx",    32'(o_Tx_Serial), 32'd1);
        check("midrst_busy",  32'(o_Busy), 32'd0);
        check("midrst_bidx",  32'(o_Byte_Index), 32'd1 - 32'd1);
        check("midrst_count", 32'(o_Word_Count), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_Word_Complete !== 1'b0 || o_Tx_Serial !== 1'b1) bad++;
        end
        check("midrst_hold", 32'(bad), 32'd0);
        rst_n = 1'b1;
        i_Word = 16'h8001;
        track_word(16'h8001, 16'd1, 0, 16'h0000, 83);

        // Count wrap: preload the counter near the top, then send words
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        check("preload_count", 32'(o_Word_Count), 32'hFFFE);
        i_Word = 16'h00FF;
        i_Enable = 1'b1;
        track_word(16'h00FF, 16'hFFFF, 83, 16'h7E81, 0);
        track_word(16'h7E81, 16'h0000, 0, 16'h0000, 83);
        check("wrap_count", 32'(o_Word_Count), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
